uart_rx_frame_decoder: RTL and testbench



---
 rtl/uart_rx_frame_decoder_pkg.sv | 20 ++
 rtl/uart_rx_frame_decoder_byte_strobe.sv | 34 +++
 rtl/uart_rx_frame_decoder.sv | 194 +++++++++++++++++++
 tb/tb_uart_rx_frame_decoder.sv | 307 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_rx_frame_decoder_pkg.sv
// Shared types and helpers for the UART frame decoder slice.
// Holds the FSM state encoding and the LEN counter width rule.
package uart_frame_pkg;

    typedef enum logic [2:0] {
        S_IDLE,
        S_LEN,
        S_PAYLOAD,
        S_CHECK,
        S_OUTPUT
    } state_e;

    localparam logic [7:0] SOF_DEFAULT = 8'hA5;

    // Width needed to hold any LEN from 0 to max_payload inclusive.
    function automatic int len_width(input int max_payload);
        return $clog2(max_payload + 1);
    endfunction

endpackage

// File: rtl/uart_rx_frame_decoder_byte_strobe.sv
// Synchronises the receiver ready level and emits one strobe per byte.
// Data is passed through during the strobe cycle, when it is stable.
module uart_byte_strobe #(
    parameter int W = 8
) (
    input  logic         clock_out,
    input  logic         nreset,
    input  logic [W-1:0] rx_data_i,
    input  logic         rx_ready_i,
    output logic         strobe_o,
    output logic [W-1:0] data_o
);

    logic sync1_q;
    logic sync2_q;
    logic prev_q;

    // Flops reset high so an idle-high receiver gives no edge at reset exit.
    always_ff @(posedge clock_out or negedge nreset) begin
        if (!nreset) begin
            sync1_q <= 1'b1;
            sync2_q <= 1'b1;
            prev_q  <= 1'b1;
        end else begin
            sync1_q <= rx_ready_i;
            sync2_q <= sync1_q;
            prev_q  <= sync2_q;
        end
    end

    assign strobe_o = sync2_q & ~prev_q;
    assign data_o   = strobe_o ? rx_data_i : '0;

endmodule

// File: rtl/uart_rx_frame_decoder.sv
// Parses SOF/LEN/payload/CHK frames from the UART byte stream and
// streams checked payload out on a valid/ready byte interface.
module uart_rx_frame_decoder
    import uart_frame_pkg::*;
#(
    parameter int BYTESIZES     = 8,
    parameter int MAX_PAYLOAD   = 16,
    parameter logic [BYTESIZES-1:0] SOF_BYTE = BYTESIZES'(SOF_DEFAULT),
    parameter int TIMEOUT_TICKS = 4096
) (
    input  logic                 clock_out,
    input  logic                 nreset,
    input  logic [BYTESIZES-1:0] rx_data,
    input  logic                 rx_ready,
    output logic [BYTESIZES-1:0] m_data,
    output logic                 m_valid,
    input  logic                 m_ready,
    output logic                 m_last,
    output logic [$clog2(MAX_PAYLOAD+1)-1:0] frame_len,
    output logic                 busy,
    output logic                 err_chk,
    output logic                 err_len,
    output logic                 err_timeout,
    output logic                 err_overrun
);

    localparam int LW = len_width(MAX_PAYLOAD);
    localparam int AW = (MAX_PAYLOAD > 1) ? $clog2(MAX_PAYLOAD) : 1;
    localparam int TW = $clog2(TIMEOUT_TICKS + 1);

    logic                 strobe;
    logic [BYTESIZES-1:0] byte_w;

    state_e               state_q;
    logic [LW-1:0]        len_q;
    logic [LW-1:0]        idx_q;
    logic [LW-1:0]        rd_idx_q;
    logic [LW-1:0]        rd_idx_d;
    logic [BYTESIZES-1:0] chk_q;
    logic [TW-1:0]        tmo_q;
    logic [BYTESIZES-1:0] buf_q [2**AW];
    logic [BYTESIZES-1:0] m_data_q;
    logic                 m_valid_q;
    logic                 m_last_q;
    logic                 err_chk_q;
    logic                 err_len_q;
    logic                 err_tmo_q;
    logic                 err_ovr_q;

    logic                 counting;
    logic                 expire;
    logic                 len_ok;
    logic                 buf_we;

    uart_byte_strobe #(
        .W(BYTESIZES)
    ) u_strobe (
        .clock_out  (clock_out),
        .nreset     (nreset),
        .rx_data_i  (rx_data),
        .rx_ready_i (rx_ready),
        .strobe_o   (strobe),
        .data_o     (byte_w)
    );

    assign counting = (state_q == S_LEN) || (state_q == S_PAYLOAD)
                   || (state_q == S_CHECK);
    // Expiry is judged before the strobe clears the counter, so it wins.
    assign expire   = counting && (tmo_q == TW'(TIMEOUT_TICKS));
    assign len_ok   = (byte_w != '0)
                   && (byte_w <= BYTESIZES'(MAX_PAYLOAD));
    assign buf_we   = (state_q == S_PAYLOAD) && strobe && !expire;
    assign rd_idx_d = rd_idx_q + LW'(1);

    always_ff @(posedge clock_out) begin
        if (buf_we) begin
            buf_q[AW'(idx_q)] <= byte_w;
        end
    end

    always_ff @(posedge clock_out or negedge nreset) begin
        if (!nreset) begin
            state_q   <= S_IDLE;
            len_q     <= '0;
            idx_q     <= '0;
            rd_idx_q  <= '0;
            chk_q     <= '0;
            tmo_q     <= '0;
            m_data_q  <= '0;
            m_valid_q <= 1'b0;
            m_last_q  <= 1'b0;
            err_chk_q <= 1'b0;
            err_len_q <= 1'b0;
            err_tmo_q <= 1'b0;
            err_ovr_q <= 1'b0;
        end else begin
            err_chk_q <= 1'b0;
            err_len_q <= 1'b0;
            err_tmo_q <= 1'b0;
            err_ovr_q <= 1'b0;

            if (!counting || strobe) begin
                tmo_q <= '0;
            end else begin
                tmo_q <= tmo_q + TW'(1);
            end

            if (expire) begin
                err_tmo_q <= 1'b1;
                state_q   <= S_IDLE;
                len_q     <= '0;
                idx_q     <= '0;
                chk_q     <= '0;
                tmo_q     <= '0;
            end else begin
                unique case (state_q)
                    S_IDLE: begin
                        if (strobe && byte_w == SOF_BYTE) begin
                            chk_q   <= '0;
                            state_q <= S_LEN;
                        end
                    end
                    S_LEN: begin
                        if (strobe) begin
                            if (len_ok) begin
                                len_q   <= LW'(byte_w);
                                idx_q   <= '0;
                                chk_q   <= chk_q ^ byte_w;
                                state_q <= S_PAYLOAD;
                            end else begin
                                err_len_q <= 1'b1;
                                state_q   <= S_IDLE;
                            end
                        end
                    end
                    S_PAYLOAD: begin
                        if (strobe) begin
                            chk_q <= chk_q ^ byte_w;
                            idx_q <= idx_q + LW'(1);
                            if (idx_q == len_q - LW'(1)) begin
                                state_q <= S_CHECK;
                            end
                        end
                    end
                    S_CHECK: begin
                        if (strobe) begin
                            if (byte_w == chk_q) begin
                                rd_idx_q  <= '0;
                                m_valid_q <= 1'b1;
                                m_data_q  <= buf_q[0];
                                m_last_q  <= (len_q == LW'(1));
                                state_q   <= S_OUTPUT;
                            end else begin
                                err_chk_q <= 1'b1;
                                state_q   <= S_IDLE;
                            end
                        end
                    end
                    S_OUTPUT: begin
                        if (strobe) begin
                            err_ovr_q <= 1'b1;
                        end
                        if (m_valid_q && m_ready) begin
                            if (m_last_q) begin
                                m_valid_q <= 1'b0;
                                m_last_q  <= 1'b0;
                                m_data_q  <= '0;
                                state_q   <= S_IDLE;
                            end else begin
                                rd_idx_q <= rd_idx_d;
                                m_data_q <= buf_q[AW'(rd_idx_d)];
                                m_last_q <= (rd_idx_d == len_q - LW'(1));
                            end
                        end
                    end
                    default: begin
                        state_q <= S_IDLE;
                    end
                endcase
            end
        end
    end

    assign m_data      = m_data_q;
    assign m_valid     = m_valid_q;
    assign m_last      = m_last_q;
    assign frame_len   = len_q;
    assign busy        = (state_q != S_IDLE);
    assign err_chk     = err_chk_q;
    assign err_len     = err_len_q;
    assign err_timeout = err_tmo_q;
    assign err_overrun = err_ovr_q;

endmodule

// File: tb/tb_uart_rx_frame_decoder.sv
// Randomised frame traffic against a frame-level reference model.
// A scoreboard queue holds expected payload; a monitor pops and compares.
module tb_uart_rx_frame_decoder;

    localparam int MAXP = 16;
    localparam int TMO  = 64;
    localparam logic [7:0] SOF = 8'hA5;

    localparam int O_NONE = 0;
    localparam int O_GOOD = 1;
    localparam int O_LEN  = 2;
    localparam int O_CHK  = 3;
    localparam int O_TMO  = 4;

    typedef logic [7:0] bq_t[$];
    typedef struct {
        logic [7:0] d;
        logic       last;
        int         len;
    } exp_t;

    logic       clock_out = 1'b0;
    logic       nreset    = 1'b0;
    logic [7:0] rx_data   = 8'h00;
    logic       rx_ready  = 1'b1;
    logic [7:0] m_data;
    logic       m_valid;
    logic       m_ready   = 1'b1;
    logic       m_last;
    logic [4:0] frame_len;
    logic       busy;
    logic       err_chk;
    logic       err_len;
    logic       err_timeout;
    logic       err_overrun;

    int n_checks = 0;
    int n_errors = 0;
    int rdy_mode = 0;
    int n_chk = 0, n_len = 0, n_tmo = 0, n_ovr = 0;
    int e_chk = 0, e_len = 0, e_tmo = 0, e_ovr = 0;
    exp_t sb[$];

    uart_rx_frame_decoder #(
        .BYTESIZES     (8),
        .MAX_PAYLOAD   (MAXP),
        .SOF_BYTE      (SOF),
        .TIMEOUT_TICKS (TMO)
    ) dut (
        .clock_out   (clock_out),
        .nreset      (nreset),
        .rx_data     (rx_data),
        .rx_ready    (rx_ready),
        .m_data      (m_data),
        .m_valid     (m_valid),
        .m_ready     (m_ready),
        .m_last      (m_last),
        .frame_len   (frame_len),
        .busy        (busy),
        .err_chk     (err_chk),
        .err_len     (err_len),
        .err_timeout (err_timeout),
        .err_overrun (err_overrun)
    );

    always #5 clock_out = ~clock_out;

    task automatic chk(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_errors++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    // Frame-level outcome straight from the framing rules.
    function automatic int classify(input bq_t f);
        logic [7:0] x;
        int n;
        if (f.size() < 1 || f[0] != SOF) return O_NONE;
        if (f.size() < 2) return O_TMO;
        n = int'(f[1]);
        if (n < 1 || n > MAXP) return O_LEN;
        if (f.size() < n + 3) return O_TMO;
        x = 8'h00;
        for (int i = 1; i <= n + 1; i++) x ^= f[i];
        return (f[n+2] == x) ? O_GOOD : O_CHK;
    endfunction

    // kind: 0 good, 1 corrupt checksum, 2 truncated
    function automatic bq_t make_frame(input int len, input int kind);
        bq_t f;
        logic [7:0] x, b;
        int keep;
        f.push_back(SOF);
        f.push_back(8'(len));
        x = 8'(len);
        keep = (kind == 2) ? $urandom_range(0, len - 1) : len;
        for (int i = 0; i < keep; i++) begin
            b = 8'($urandom);
            f.push_back(b);
            x ^= b;
        end
        if (kind == 0) f.push_back(x);
        if (kind == 1) f.push_back(x ^ 8'($urandom_range(1, 255)));
        return f;
    endfunction

    task automatic send_byte(input logic [7:0] b);
        rx_ready = 1'b0;
        repeat (2) @(negedge clock_out);
        rx_data  = b;
        rx_ready = 1'b1;
        repeat (4) @(negedge clock_out);
    endtask

    task automatic check_errs(input string tag);
        chk({tag, "_err_chk"}, n_chk, e_chk);
        chk({tag, "_err_len"}, n_len, e_len);
        chk({tag, "_err_timeout"}, n_tmo, e_tmo);
        chk({tag, "_err_overrun"}, n_ovr, e_ovr);
    endtask

    task automatic wait_idle(input string tag);
        int k;
        k = 0;
        while ((sb.size() != 0 || m_valid || busy) && k < 3000) begin
            @(negedge clock_out);
            k++;
        end
        chk({tag, "_drain_timeout"}, int'(k >= 3000), 0);
        repeat (2) @(negedge clock_out);
        chk({tag, "_busy"}, busy, 0);
        chk({tag, "_sb_left"}, sb.size(), 0);
        check_errs(tag);
    endtask

    task automatic run_frame(input string tag, input bq_t f);
        int o, n;
        o = classify(f);
        if (o == O_GOOD) begin
            n = int'(f[1]);
            for (int i = 0; i < n; i++) sb.push_back('{f[2+i], i == n - 1, n});
        end
        foreach (f[i]) send_byte(f[i]);
        if (o == O_LEN) e_len++;
        if (o == O_CHK) e_chk++;
        if (o == O_TMO) e_tmo++;
        wait_idle(tag);
    endtask

    // Monitor: drives m_ready, pops the scoreboard on each transfer.
    initial begin
        int cyc, last_cyc, tog;
        bit first, stall;
        logic [7:0] pd;
        logic pl;
        exp_t e;
        cyc = 0; last_cyc = 0; tog = 0;
        first = 1'b1; stall = 1'b0; pd = '0; pl = 1'b0;
        forever begin
            @(negedge clock_out);
            cyc++;
            case (rdy_mode)
                0: m_ready = 1'b1;
                1: m_ready = 1'($urandom_range(0, 1));
                2: m_ready = 1'b0;
                default: begin
                    m_ready = (tog % 4 == 0) || (tog % 4 == 3);
                    tog++;
                end
            endcase
            if (!nreset) begin
                stall = 1'b0;
                first = 1'b1;
            end else begin
                if (stall) begin
                    chk("stall_valid", m_valid, 1);
                    chk("stall_data", m_data, pd);
                    chk("stall_last", m_last, pl);
                end
                if (m_valid && m_ready) begin
                    n_checks++;
                    if (sb.size() == 0) begin
                        n_errors++;
                        $display("FAIL unexpected_output: got %0h, expected none", m_data);
                    end else begin
                        e = sb.pop_front();
                        chk("m_data", m_data, e.d);
                        chk("m_last", m_last, e.last);
                        chk("frame_len", frame_len, e.len);
                        if (rdy_mode == 0 && !first) chk("back_to_back", cyc - last_cyc, 1);
                        last_cyc = cyc;
                        first = e.last;
                    end
                end
                stall = m_valid && !m_ready;
                pd = m_data;
                pl = m_last;
                if (err_chk) n_chk++;
                if (err_len) n_len++;
                if (err_timeout) n_tmo++;
                if (err_overrun) n_ovr++;
            end
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: got no finish, expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        bq_t f;
        int kind, k;
        repeat (3) @(negedge clock_out);
        chk("rst_m_valid", m_valid, 0);
        chk("rst_busy", busy, 0);
        nreset = 1'b1;
        repeat (3) @(negedge clock_out);
        chk("reset_m_data", m_data, 0);
        chk("reset_m_valid", m_valid, 0);
        chk("reset_m_last", m_last, 0);
        chk("reset_frame_len", frame_len, 0);
        chk("reset_busy", busy, 0);
        check_errs("reset");

        rdy_mode = 0;
        f = '{8'hA5, 8'h03, 8'h11, 8'h22, 8'h33, 8'h03};
        run_frame("good3", f);

        f = '{8'hA5, 8'h02, 8'hAA, 8'h55, 8'h00};
        run_frame("badchk", f);

        f = '{8'hA5, 8'h00};
        run_frame("len0", f);
        f = '{8'hA5, 8'(MAXP + 1)};
        run_frame("len17", f);
        run_frame("after_len", make_frame(MAXP, 0));
        run_frame("len1", make_frame(1, 0));

        f = '{8'hA5, 8'h02, 8'h10};
        run_frame("timeout", f);
        run_frame("after_tmo", make_frame(5, 0));

        // Overrun: stall the stream, strobe a byte, then resume with a toggling ready.
        rdy_mode = 2;
        f = make_frame(4, 0);
        for (int i = 0; i < 4; i++) sb.push_back('{f[2+i], i == 3, 4});
        foreach (f[i]) send_byte(f[i]);
        k = 0;
        while (!m_valid && k < 100) begin
            @(negedge clock_out);
            k++;
        end
        chk("ovr_valid_wait", int'(k >= 100), 0);
        send_byte(SOF);
        e_ovr++;
        repeat (3) @(negedge clock_out);
        rdy_mode = 3;
        wait_idle("overrun");
        rdy_mode = 0;
        run_frame("after_ovr", make_frame(3, 0));

        // Reset in the middle of a payload.
        f = make_frame(5, 0);
        for (int i = 0; i < 4; i++) send_byte(f[i]);
        @(negedge clock_out);
        nreset = 1'b0;
        #1;
        chk("midrst_busy", busy, 0);
        chk("midrst_m_valid", m_valid, 0);
        chk("midrst_frame_len", frame_len, 0);
        chk("midrst_errs", {err_chk, err_len, err_timeout, err_overrun}, 0);
        repeat (3) @(negedge clock_out);
        nreset = 1'b1;
        repeat (2) @(negedge clock_out);
        run_frame("after_rst", make_frame(5, 0));

        for (int it = 0; it < 40; it++) begin
            kind = $urandom_range(0, 5);
            rdy_mode = (kind == 1) ? 1 : (kind == 0 ? 0 : 3);
            case (kind)
                0, 1: f = make_frame($urandom_range(1, MAXP), 0);
                2: f = make_frame($urandom_range(1, MAXP), 1);
                3: begin
                    f = '{SOF, 8'h00};
                    if ($urandom_range(0, 1) == 1) f[1] = 8'($urandom_range(MAXP + 1, 255));
                end
                4: begin
                    f = {};
                    for (int j = 0; j < 3; j++) begin
                        f.push_back(8'($urandom));
                        if (f[j] == SOF) f[j] = 8'h00;
                    end
                end
                default: f = make_frame($urandom_range(1, MAXP), 2);
            endcase
            run_frame("rand", f);
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
